work_shift_tx: RTL and testbench
================================

Name: work_shift_tx

Overview:
- Host-side transmitter that feeds one unit of mining work into the hash core's shift-in interface.
- Holds a 24-word work buffer: midstate words 0-7, then remaining block words 8-23.
- On command, streams the buffer out one word per accepted handshake: 8 midstate words first, then 16 remaining words.
- Produces the per-word strobe and the phase-complete flags that the core's shift timer counts against.

Parameters:
- WORD_W, 32, width of one shifted word
- MID_WORDS, 8, number of midstate words (phase 1)
- REM_WORDS, 16, number of remaining block words (phase 2)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  5  buffer word index, 0..23
- wr_data  in  WORD_W  buffer write data
- load_go  in  1  start streaming the buffer (single-cycle pulse)
- abort  in  1  synchronous cancel of the stream in progress
- shift_ready  in  1  receiver accepts the word this cycle
- shift_valid  out  1  word on shift_data is valid (the receiver's start_found)
- shift_data  out  WORD_W  current word
- tx_phase  out  3  state code mirrored to the controller: 001 while sending midstate, 010 while sending remaining, 000 otherwise
- midstate_sent  out  1  one-cycle pulse after the 8th midstate transfer
- remaining_sent  out  1  one-cycle pulse after the 16th remaining transfer
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, word index 0. Buffer contents are not reset; they are undefined until written.
- Transfer definition: a transfer occurs on a rising edge where shift_valid=1 and shift_ready=1.
- While shift_valid=1 and shift_ready=0, shift_data is held stable and nothing advances.
- All outputs are registered.
- Buffer write:
  - In IDLE, wr_en with wr_addr<24 writes wr_data at the edge.
  - wr_addr>=24 is ignored.
  - Writes outside IDLE are ignored, so the buffer is frozen while streaming.
- FSM states: IDLE, SEND_MID, SEND_REM, DONE.
- IDLE:
  - load_go at an edge moves the FSM to SEND_MID.
  - In the same edge: index=0, shift_valid=1, shift_data=buf[0], tx_phase=001.
  - If wr_en and load_go occur in the same cycle, the write lands first and the stream uses the new value, including a write to word 0.
- SEND_MID:
  - Each transfer increments the index and loads shift_data=buf[index+1].
  - The transfer of word MID_WORDS-1 moves the FSM to SEND_REM with shift_data=buf[8], tx_phase=010 and midstate_sent=1 for exactly one cycle.
  - shift_valid stays 1 across the phase boundary, so there is no bubble.
- SEND_REM:
  - Transfers continue through buf[8..23].
  - The transfer of word 23 moves the FSM to DONE: shift_valid=0, tx_phase=000, remaining_sent=1 for one cycle.
- DONE: unconditionally returns to IDLE on the next edge, so busy drops one cycle after remaining_sent.
- Latency: with shift_ready held at 1, word 0 appears 1 cycle after load_go, and the 24 transfers occupy 24 consecutive cycles.
- load_go is ignored when the FSM is not in IDLE.
- abort:
  - abort=1 in any non-IDLE state moves the FSM to IDLE at the next edge: shift_valid=0, tx_phase=000, index=0.
  - No sent pulse is generated for an incomplete phase.
  - abort has priority over a transfer on the same edge.
  - abort in IDLE has no effect.
- Reset mid-stream: immediately returns all outputs to 0. A following load_go restarts the stream from word 0.
- Index arithmetic: 5-bit, never exceeds 23, no wrap-around past the buffer.

Test Plan:
- Fill buf[i]=0xA5000000+i, pulse load_go, shift_ready=1 constant.
  - shift_data reads 0xA5000000..0xA5000017 on 24 consecutive cycles.
  - midstate_sent pulses in the same cycle shift_data=0xA5000008.
  - remaining_sent pulses in the cycle after the last word.
  - busy falls 1 cycle after that.
- Same fill, shift_ready toggling 1,0,0,1,... (random).
  - Data holds while shift_ready=0.
  - Exactly 24 transfers occur, in order, with no duplicates.
  - tx_phase is 001 for transfers 1-8 and 010 for transfers 9-24.
- Writes during streaming:
  - wr_en to addr 3 with 0xDEADBEEF during SEND_MID is ignored; the stream still emits 0xA5000003.
  - In IDLE, wr_en to addr 30 is dropped and no buffer word changes.
- Same-cycle write and start: wr_en addr 0 =0x12345678 together with load_go; the first word out is 0x12345678.
- abort after 5 transfers in SEND_MID.
  - Next cycle: shift_valid=0, busy=0, no midstate_sent.
  - A new load_go restarts at buf[0]; a load_go issued mid-stream before the abort is ignored.
- n_rst asserted during SEND_REM: outputs go to 0 asynchronously; after release, load_go yields a full, correct 24-word stream.

Source files
------------

// File: rtl/work_shift_tx.sv
// work_shift_tx: holds one 24-word unit of mining work (8 midstate words,
// then 16 remaining block words) and streams it into the hash core's
// shift-in port, one word per valid/ready handshake.
module work_shift_tx #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned MID_WORDS = 8,
  parameter int unsigned REM_WORDS = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              load_go,
  input  logic              abort,
  input  logic              shift_ready,
  output logic              shift_valid,
  output logic [WORD_W-1:0] shift_data,
  output logic [2:0]        tx_phase,
  output logic              midstate_sent,
  output logic              remaining_sent,
  output logic              busy
);

  localparam int unsigned TOTAL     = MID_WORDS + REM_WORDS;
  localparam logic [4:0]  NUM_WORDS = 5'(TOTAL);
  localparam logic [4:0]  LAST_MID  = 5'(MID_WORDS - 1);
  localparam logic [4:0]  LAST_WORD = 5'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_MID,
    SEND_REM,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [4:0]        idx, idx_n, nxt;
  logic              valid_n, mid_n, rem_n, busy_n;
  logic [WORD_W-1:0] data_n, word0, nxt_word;
  logic [2:0]        phase_n;
  logic              wr_ok, xfer;

  logic [WORD_W-1:0] mem [TOTAL];

  assign wr_ok = wr_en && (wr_addr < NUM_WORDS) && (state == IDLE);
  assign xfer  = shift_valid && shift_ready;
  assign nxt   = idx + 5'd1;

  // A write to word 0 in the same cycle as load_go must be seen by the stream.
  assign word0    = (wr_en && (wr_addr == 5'd0)) ? wr_data : mem[0];
  assign nxt_word = (nxt < NUM_WORDS) ? mem[nxt] : '0;

  // Work buffer: writable only while idle, contents never reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      idx            <= '0;
      shift_valid    <= 1'b0;
      shift_data     <= '0;
      tx_phase       <= '0;
      midstate_sent  <= 1'b0;
      remaining_sent <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      shift_valid    <= valid_n;
      shift_data     <= data_n;
      tx_phase       <= phase_n;
      midstate_sent  <= mid_n;
      remaining_sent <= rem_n;
      busy           <= busy_n;
    end
  end

  // Next-state and next-output values; abort outranks any transfer.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = shift_valid;
    data_n  = shift_data;
    phase_n = tx_phase;
    mid_n   = 1'b0;
    rem_n   = 1'b0;

    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      idx_n   = '0;
      valid_n = 1'b0;
      phase_n = 3'b000;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_go) begin
            state_n = SEND_MID;
            idx_n   = '0;
            valid_n = 1'b1;
            data_n  = word0;
            phase_n = 3'b001;
          end
        end
        SEND_MID: begin
          if (xfer) begin
            idx_n  = nxt;
            data_n = nxt_word;
            if (idx == LAST_MID) begin
              state_n = SEND_REM;
              phase_n = 3'b010;
              mid_n   = 1'b1;
            end
          end
        end
        SEND_REM: begin
          if (xfer) begin
            if (idx == LAST_WORD) begin
              state_n = DONE;
              idx_n   = '0;
              valid_n = 1'b0;
              phase_n = 3'b000;
              rem_n   = 1'b1;
            end else begin
              idx_n  = nxt;
              data_n = nxt_word;
            end
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_work_shift_tx.sv
// Directed bench for work_shift_tx: full streams, back-pressure, frozen
// buffer, write/start collision, abort and mid-stream reset.
module tb_work_shift_tx;

  logic        clk;
  logic        n_rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        load_go;
  logic        abort;
  logic        shift_ready;
  logic        shift_valid;
  logic [31:0] shift_data;
  logic [2:0]  tx_phase;
  logic        midstate_sent;
  logic        remaining_sent;
  logic        busy;

  int checks = 0;
  int errors = 0;

  work_shift_tx #(
    .WORD_W   (32),
    .MID_WORDS(8),
    .REM_WORDS(16)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .load_go       (load_go),
    .abort         (abort),
    .shift_ready   (shift_ready),
    .shift_valid   (shift_valid),
    .shift_data    (shift_data),
    .tx_phase      (tx_phase),
    .midstate_sent (midstate_sent),
    .remaining_sent(remaining_sent),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step;
    wr_en   = 1'b0;
  endtask

  task automatic start;
    load_go = 1'b1;
    step;
    load_go = 1'b0;
  endtask

  // Expects word 'first' on the output and shift_ready=1; runs to IDLE.
  task automatic stream_from(input int first);
    for (int i = first; i < 24; i++) begin
      chk("stream_data", shift_data, 32'hA500_0000 + 32'(i));
      chk("stream_valid", {31'b0, shift_valid}, 32'd1);
      chk("stream_phase", {29'b0, tx_phase}, (i < 8) ? 32'd1 : 32'd2);
      chk("stream_mid_sent", {31'b0, midstate_sent}, (i == 8) ? 32'd1 : 32'd0);
      chk("stream_busy", {31'b0, busy}, 32'd1);
      step;
    end
    chk("done_valid", {31'b0, shift_valid}, 32'd0);
    chk("done_rem_sent", {31'b0, remaining_sent}, 32'd1);
    chk("done_phase", {29'b0, tx_phase}, 32'd0);
    chk("done_busy", {31'b0, busy}, 32'd1);
    step;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_rem_sent", {31'b0, remaining_sent}, 32'd0);
  endtask

  initial begin
    int   exp_i;
    int   cyc;
    logic r;
    logic last_x;

    n_rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    load_go = 1'b0; abort = 1'b0; shift_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, shift_valid}, 32'd0);
    chk("rst_data", shift_data, 32'd0);
    chk("rst_phase", {29'b0, tx_phase}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid", {31'b0, midstate_sent}, 32'd0);
    chk("rst_rem", {31'b0, remaining_sent}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step;

    for (int i = 0; i < 24; i++) write(5'(i), 32'hA500_0000 + 32'(i));

    // Full stream with constant ready.
    start;
    stream_from(0);

    // Random back-pressure.
    exp_i  = 0;
    cyc    = 0;
    last_x = 1'b0;
    start;
    while (exp_i < 24 && cyc < 300) begin
      chk("bp_valid", {31'b0, shift_valid}, 32'd1);
      chk("bp_data", shift_data, 32'hA500_0000 + 32'(exp_i));
      chk("bp_phase", {29'b0, tx_phase}, (exp_i < 8) ? 32'd1 : 32'd2);
      chk("bp_mid_sent", {31'b0, midstate_sent}, (last_x && exp_i == 8) ? 32'd1 : 32'd0);
      r = 1'($urandom_range(0, 1));
      shift_ready = r;
      step;
      last_x = r;
      if (r) exp_i++;
      cyc++;
    end
    chk("bp_count", 32'(exp_i), 32'd24);
    chk("bp_end_valid", {31'b0, shift_valid}, 32'd0);
    chk("bp_end_rem", {31'b0, remaining_sent}, 32'd1);
    shift_ready = 1'b1;
    step;
    chk("bp_end_busy", {31'b0, busy}, 32'd0);

    // Write during SEND_MID must not reach the buffer.
    start;
    for (int i = 0; i < 24; i++) begin
      chk("frz_data", shift_data, 32'hA500_0000 + 32'(i));
      wr_en   = (i == 1);
      wr_addr = 5'd3;
      wr_data = 32'hDEAD_BEEF;
      step;
    end
    wr_en = 1'b0;
    chk("frz_rem", {31'b0, remaining_sent}, 32'd1);
    step;
    chk("frz_busy", {31'b0, busy}, 32'd0);

    // Out-of-range address in IDLE is dropped.
    write(5'd30, 32'hFFFF_FFFF);

    // Same-cycle write to word 0 and start.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; load_go = 1'b1;
    step;
    wr_en = 1'b0; load_go = 1'b0;
    chk("coll_data", shift_data, 32'h1234_5678);
    chk("coll_phase", {29'b0, tx_phase}, 32'd1);
    step;
    stream_from(1);
    write(5'd0, 32'hA500_0000);

    // Abort after 5 transfers; a load_go mid-stream is ignored.
    start;
    for (int i = 0; i < 5; i++) begin
      chk("ab_data", shift_data, 32'hA500_0000 + 32'(i));
      load_go = (i == 2);
      step;
    end
    load_go = 1'b0;
    chk("ab_pre_data", shift_data, 32'hA500_0005);
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("ab_valid", {31'b0, shift_valid}, 32'd0);
    chk("ab_busy", {31'b0, busy}, 32'd0);
    chk("ab_phase", {29'b0, tx_phase}, 32'd0);
    chk("ab_mid", {31'b0, midstate_sent}, 32'd0);
    step;
    chk("ab_idle_valid", {31'b0, shift_valid}, 32'd0);
    start;
    stream_from(0);

    // Asynchronous reset during SEND_REM.
    start;
    repeat (12) step;
    chk("rr_pre_phase", {29'b0, tx_phase}, 32'd2);
    chk("rr_pre_data", shift_data, 32'hA500_000C);
    #2 n_rst = 1'b0;
    #1;
    chk("rr_valid", {31'b0, shift_valid}, 32'd0);
    chk("rr_data", shift_data, 32'd0);
    chk("rr_phase", {29'b0, tx_phase}, 32'd0);
    chk("rr_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    step;
    start;
    stream_from(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
